// File: rtl/frame_accumulator.sv
// Frame accumulator: takes exactly N samples per frame over valid/ready and
// presents their sum and maximum on an output handshake, steering an external mod-N counter.
module frame_accumulator #(
    parameter int unsigned N  = 5,
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          cnt_en,
    output logic          cnt_clr,
    input  logic          cnt_co,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [DW-1:0] out_max,
    output logic          busy
);

    localparam int unsigned MIN_SW = DW + $clog2(N);

    generate
        if (SW < MIN_SW) begin : g_sw_check
            $error("frame_accumulator: SW too narrow for N samples of DW bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [DW-1:0] max_q, max_d;
    logic          accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
        end
    end

    // Abort outranks a simultaneous beat, so it gates in_ready before acceptance.
    always_comb begin
        in_ready  = (state_q == ACC) && !abort;
        accept    = in_valid && in_ready;
        cnt_en    = accept;
        cnt_clr   = ((state_q == IDLE) && start) || ((state_q == ACC) && abort);
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        out_sum   = sum_q;
        out_max   = max_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = ACC;
            ACC: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && cnt_co) begin
                    state_d = OUT;
                end
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        if ((state_q == IDLE) && start) begin
            sum_d = '0;
            max_d = '0;
        end else if (accept) begin
            sum_d = sum_q + {{(SW-DW){1'b0}}, in_data};
            if (in_data > max_q) begin
                max_d = in_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_accumulator.sv
// Bench for frame_accumulator: an inline mod-N counter, a queue-based frame model,
// a vector table for the basic frame, directed corner sequences and random traffic.
module tb_frame_accumulator;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, cnt_en, cnt_clr, cnt_co, out_valid, busy;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_max;
    logic [2:0]    cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = idle, 1 = collecting, 2 = result pending
    int mode = 0;
    int samples[$];
    int en_pulses  = 0;
    int clr_pulses = 0;

    always #5 clk = ~clk;

    frame_accumulator #(.N(N), .DW(DW), .SW(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .cnt_co   (cnt_co),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_max  (out_max),
        .busy     (busy)
    );

    // External mod-N counter
    always @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= '0;
        else if (cnt_clr)  cnt <= '0;
        else if (cnt_en)   cnt <= (cnt == 3'(N - 1)) ? '0 : cnt + 3'd1;
    end
    assign cnt_co = (cnt == 3'(N - 1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (samples[i]) s += samples[i];
        return s % (1 << SW);
    endfunction

    function automatic int model_max();
        int m = 0;
        foreach (samples[i]) if (samples[i] > m) m = samples[i];
        return m;
    endfunction

    task automatic drive(input logic s, input logic a, input logic v, input int d, input logic r);
        start     = s;
        abort     = a;
        in_valid  = v;
        in_data   = DW'(d);
        out_ready = r;
    endtask

    // Called at the falling edge: compares the DUT against the model for this cycle.
    task automatic model_check();
        logic e_ir, e_en, e_clr;
        e_ir  = (mode == 1) && !abort;
        e_en  = e_ir && in_valid;
        e_clr = ((mode == 0) && start) || ((mode == 1) && abort);
        chk("in_ready", int'(in_ready), int'(e_ir));
        chk("cnt_en", int'(cnt_en), int'(e_en));
        chk("cnt_clr", int'(cnt_clr), int'(e_clr));
        chk("out_valid", int'(out_valid), int'(mode == 2));
        chk("busy", int'(busy), int'(mode != 0));
        chk("en_clr_exclusive", int'(cnt_en && cnt_clr), 0);
        if (mode == 2) begin
            chk("out_sum", int'(out_sum), model_sum());
            chk("out_max", int'(out_max), model_max());
        end
        if (cnt_en)  en_pulses++;
        if (cnt_clr) clr_pulses++;
    endtask

    // Advances the model by one clock and moves to just after the rising edge.
    task automatic advance();
        case (mode)
            0: if (start) begin
                samples.delete();
                mode = 1;
            end
            1: begin
                if (abort) begin
                    samples.delete();
                    mode = 0;
                end else if (in_valid) begin
                    samples.push_back(int'(in_data));
                    if (samples.size() == N) mode = 2;
                end
            end
            default: if (out_ready) mode = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        advance();
    endtask

    typedef struct {
        logic     s, v, r;
        int       d;
        logic     e_ir, e_en, e_clr, e_ov;
        int       e_sum, e_max;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 9, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 24, 9};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_max", int'(out_max), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame from the vector table
        en_pulses = 0;
        clr_pulses = 0;
        foreach (tbl[i]) begin
            drive(tbl[i].s, 0, tbl[i].v, tbl[i].d, tbl[i].r);
            @(negedge clk);
            chk("tbl_in_ready", int'(in_ready), int'(tbl[i].e_ir));
            chk("tbl_cnt_en", int'(cnt_en), int'(tbl[i].e_en));
            chk("tbl_cnt_clr", int'(cnt_clr), int'(tbl[i].e_clr));
            chk("tbl_out_valid", int'(out_valid), int'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk("tbl_out_sum", int'(out_sum), tbl[i].e_sum);
                chk("tbl_out_max", int'(out_max), tbl[i].e_max);
            end
            model_check();
            advance();
        end
        chk("basic_en_pulses", en_pulses, 5);
        chk("basic_clr_pulses", clr_pulses, 1);

        // Stalled input: valid on alternate cycles
        drive(1, 0, 0, 0, 1); step();
        begin
            int d[5] = '{3, 7, 1, 9, 4};
            foreach (d[i]) begin
                drive(0, 0, 1, d[i], 1); step();
                if (i < 4) begin
                    drive(0, 0, 0, 99, 1); step();
                end
            end
        end
        @(negedge clk);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_sum", int'(out_sum), 24);
        model_check();
        advance();
        drive(0, 0, 0, 0, 0); step();

        // Output backpressure with start pulses during OUT
        drive(1, 0, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 10 + i * 20, 0); step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(i[0], i[1], 1, 200, 0); step();
        end
        drive(1, 0, 1, 200, 1); step();
        drive(0, 0, 1, 200, 0); step();
        chk("bp_idle_after_hs", int'(busy), 0);

        // Abort with the third sample, then an all-255 frame
        drive(1, 0, 0, 0, 1); step();
        drive(0, 0, 1, 50, 1); step();
        drive(0, 0, 1, 60, 1); step();
        drive(0, 1, 1, 70, 1); step();
        drive(0, 0, 0, 0, 1); step();
        drive(1, 0, 0, 0, 1); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 255, 0); step();
        end
        @(negedge clk);
        chk("abort_next_sum", int'(out_sum), 1275);
        chk("abort_next_max", int'(out_max), 255);
        model_check();
        drive(0, 0, 0, 0, 1);
        advance();

        // Asynchronous reset after two accepted samples
        drive(1, 0, 0, 0, 1); step();
        drive(0, 0, 1, 40, 1); step();
        drive(0, 0, 1, 41, 1); step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_sum", int'(out_sum), 0);
        chk("arst_max", int'(out_max), 0);
        mode = 0;
        samples.delete();
        drive(0, 0, 0, 0, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0); step();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 1, i, 0); step();
        end
        @(negedge clk);
        chk("arst_frame_sum", int'(out_sum), 15);
        chk("arst_frame_max", int'(out_max), 5);
        model_check();
        drive(0, 0, 0, 0, 1);
        advance();

        // Back-to-back frames, start in the first idle cycle
        for (int f = 0; f < 2; f++) begin
            drive(1, 0, 0, 0, 1); step();
            for (int i = 0; i < 5; i++) begin
                drive(0, 0, 1, (f == 0) ? 200 - i : 2 + i, 1); step();
            end
            drive(0, 0, 0, 0, 1); step();
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 3) != 0,
                  int'($urandom_range(0, 255)), ($urandom % 2) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
